// File: rtl/ccu_snoop_sequencer_pkg.sv
// Shared types and constants for the CCU snoop sequencer: CR response
// bit layout, snoop request bundle, FSM encoding and the lowest-index
// select used to pick the CD data supplier.
package ccu_snoop_sequencer_pkg;

    localparam int unsigned NB_CORES           = 2;
    localparam int unsigned AddrWidth          = 64;
    localparam int unsigned SnoopTimeoutCycles = 1024;
    // Upper bound on snooped cores; sizes the lowest-index select.
    localparam int unsigned MaxCores           = 4;

    typedef logic [3:0] acsnoop_t;
    typedef logic [2:0] acprot_t;

    // Packed so that bit 0 is DataTransfer and bit 4 is WasUnique.
    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } cr_resp_bits_t;

    localparam int unsigned CrRespWidth = $bits(cr_resp_bits_t);

    typedef struct packed {
        logic [AddrWidth-1:0]        addr;
        acsnoop_t                    snoop;
        acprot_t                     prot;
        logic [$clog2(NB_CORES)-1:0] initiator;
    } snoop_req_t;

    typedef enum logic [1:0] {
        SnpIdle  = 2'd0,
        SnpBcast = 2'd1,
        SnpResp  = 2'd2
    } snp_state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [1:0] lowest_set_idx(input logic [MaxCores-1:0] mask);
        logic [1:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MaxCores; i++) begin
            if (mask[i] && !found) begin
                idx   = 2'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ccu_snoop_sequencer.sv
// ACE snoop sequencer: broadcasts one snoop on AC to every core except the
// initiator, collects the CR responses, reduces them to a single result and
// holds it until the CCU datapath consumes it.
module ccu_snoop_sequencer
    import ccu_snoop_sequencer_pkg::*;
#(
    parameter int unsigned NbCores       = NB_CORES,
    parameter int unsigned AddrWidth     = ccu_snoop_sequencer_pkg::AddrWidth,
    parameter int unsigned TimeoutCycles = SnoopTimeoutCycles,
    localparam int unsigned IdxW         = (NbCores > 1) ? $clog2(NbCores) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [AddrWidth-1:0]           req_addr_i,
    input  logic [3:0]                     req_snoop_i,
    input  logic [2:0]                     req_prot_i,
    input  logic [IdxW-1:0]                req_initiator_i,
    output logic [NbCores-1:0]             ac_valid_o,
    input  logic [NbCores-1:0]             ac_ready_i,
    output logic [AddrWidth-1:0]           ac_addr_o,
    output logic [3:0]                     ac_snoop_o,
    output logic [2:0]                     ac_prot_o,
    input  logic [NbCores-1:0]             cr_valid_i,
    output logic [NbCores-1:0]             cr_ready_o,
    input  logic [CrRespWidth*NbCores-1:0] cr_resp_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic                           res_data_avail_o,
    output logic [IdxW-1:0]                res_data_src_o,
    output logic                           res_is_shared_o,
    output logic                           res_pass_dirty_o,
    output logic                           res_error_o,
    output logic                           res_timeout_o
);

    localparam int unsigned TimerW = $clog2(TimeoutCycles) + 1;

    snp_state_e             state_q,   state_d;
    logic [AddrWidth-1:0]   addr_q,    addr_d;
    acsnoop_t               snoop_q,   snoop_d;
    acprot_t                prot_q,    prot_d;
    logic [NbCores-1:0]     ac_pend_q, ac_pend_d;
    logic [NbCores-1:0]     cr_pend_q, cr_pend_d;
    logic [NbCores-1:0]     dt_mask_q, dt_mask_d;
    logic                   shared_q,  shared_d;
    logic                   dirty_q,   dirty_d;
    logic                   err_q,     err_d;
    logic                   timeout_q, timeout_d;
    logic [TimerW-1:0]      timer_q,   timer_d;

    cr_resp_bits_t          cr_bits [NbCores];
    logic [NbCores-1:0]     unused_was_unique;
    logic [NbCores-1:0]     tgt_mask;
    logic [NbCores-1:0]     cr_hs;
    logic [MaxCores-1:0]    dt_ext;
    logic [1:0]             src_full;

    // Unpack the flat CR response bus into per-core fields.
    always_comb begin
        for (int unsigned i = 0; i < NbCores; i++) begin
            cr_bits[i]           = cr_resp_bits_t'(cr_resp_i[CrRespWidth*i +: CrRespWidth]);
            unused_was_unique[i] = cr_bits[i].was_unique;
        end
    end

    // Every core except the initiator; an out-of-range initiator targets all.
    always_comb begin
        tgt_mask = '0;
        for (int unsigned i = 0; i < NbCores; i++) begin
            tgt_mask[i] = (req_initiator_i != IdxW'(i));
        end
    end

    // Lowest-index data supplier, independent of CR arrival order.
    always_comb begin
        dt_ext                = '0;
        dt_ext[NbCores-1:0]   = dt_mask_q;
        src_full              = lowest_set_idx(dt_ext);
        res_data_src_o        = src_full[IdxW-1:0];
    end

    // Next-state, handshake and accumulator logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        snoop_d     = snoop_q;
        prot_d      = prot_q;
        ac_pend_d   = ac_pend_q;
        cr_pend_d   = cr_pend_q;
        dt_mask_d   = dt_mask_q;
        shared_d    = shared_q;
        dirty_d     = dirty_q;
        err_d       = err_q;
        timeout_d   = timeout_q;
        timer_d     = timer_q;
        req_ready_o = 1'b0;
        ac_valid_o  = '0;
        cr_ready_o  = '0;
        res_valid_o = 1'b0;
        cr_hs       = '0;

        unique case (state_q)
            SnpIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d    = req_addr_i;
                    snoop_d   = req_snoop_i;
                    prot_d    = req_prot_i;
                    ac_pend_d = tgt_mask;
                    cr_pend_d = tgt_mask;
                    dt_mask_d = '0;
                    shared_d  = 1'b0;
                    dirty_d   = 1'b0;
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                    timer_d   = '0;
                    state_d   = SnpBcast;
                end
            end
            SnpBcast: begin
                ac_valid_o = ac_pend_q;
                cr_ready_o = cr_pend_q & ~ac_pend_q;
                cr_hs      = cr_ready_o & cr_valid_i;
                ac_pend_d  = ac_pend_q & ~ac_ready_i;
                cr_pend_d  = cr_pend_q & ~cr_hs;
                for (int unsigned i = 0; i < NbCores; i++) begin
                    if (cr_hs[i]) begin
                        dt_mask_d[i] = cr_bits[i].data_transfer & ~cr_bits[i].error;
                        shared_d     = shared_d | cr_bits[i].is_shared;
                        dirty_d      = dirty_d  | cr_bits[i].pass_dirty;
                        err_d        = err_d    | cr_bits[i].error;
                    end
                end
                // A CR is only accepted after its AC handshake, so an empty
                // cr_pend also implies every AC has completed.
                if (cr_pend_d == '0) begin
                    state_d = SnpResp;
                end else if (ac_pend_q == '0) begin
                    if (timer_q == TimerW'(TimeoutCycles - 1)) begin
                        timeout_d = 1'b1;
                        err_d     = 1'b1;
                        cr_pend_d = '0;
                        state_d   = SnpResp;
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
            end
            SnpResp: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = SnpIdle;
                end
            end
            default: state_d = SnpIdle;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= SnpIdle;
            addr_q    <= '0;
            snoop_q   <= '0;
            prot_q    <= '0;
            ac_pend_q <= '0;
            cr_pend_q <= '0;
            dt_mask_q <= '0;
            shared_q  <= 1'b0;
            dirty_q   <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            snoop_q   <= snoop_d;
            prot_q    <= prot_d;
            ac_pend_q <= ac_pend_d;
            cr_pend_q <= cr_pend_d;
            dt_mask_q <= dt_mask_d;
            shared_q  <= shared_d;
            dirty_q   <= dirty_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            timer_q   <= timer_d;
        end
    end

    assign ac_addr_o        = addr_q;
    assign ac_snoop_o       = snoop_q;
    assign ac_prot_o        = prot_q;
    assign res_data_avail_o = |dt_mask_q;
    assign res_is_shared_o  = shared_q;
    assign res_pass_dirty_o = dirty_q;
    assign res_error_o      = err_q;
    assign res_timeout_o    = timeout_q;

endmodule
